mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_pkg.sv | 7 +
 rtl/mem_copy_engine.sv | 125 ++++++++++++
 tb/tb_mem_copy_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the word-copy engine.
package mem_copy_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int MEM_A_W    = 16;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
endpackage

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: READ/WRITE ping-pong over a single memory port.
// Optional running checksum of copied words when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MEM_A_W-1:0] src,
  input  logic [MEM_A_W-1:0] dst,
  input  logic [ADDR_W:0]    len,
  output logic               busy,
  output logic               done,
  output logic [MEM_A_W-1:0] mem_a,
  output logic [DATA_W-1:0]  mem_wd,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [DATA_W-1:0]  mem_rd
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]  checksum
`endif
);
  localparam int LW = ADDR_W + 1;
  localparam logic [MEM_A_W-1:0] AMASK = MEM_A_W'((64'd1 << ADDR_W) - 64'd1);

  state_e             state_q, state_d;
  logic [MEM_A_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0]      len_q, len_d, i_q, i_d;
  logic [DATA_W-1:0]  buf_q, buf_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      i_q     <= i_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    i_d     = i_q;
    buf_d   = buf_q;
    busy    = 1'b0;
    done    = 1'b0;
    mem_a   = '0;
    mem_wd  = '0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src;
          dst_d   = dst;
          len_d   = len;
          i_d     = '0;
          state_d = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        // Masking the full-width sum gives the modulo-2^ADDR_W wrap and zero upper bits.
        mem_a   = (src_q + MEM_A_W'(i_q)) & AMASK;
        mem_re  = 1'b1;
        buf_d   = mem_rd;
        state_d = WRITE;
      end
      WRITE: begin
        mem_a   = (dst_q + MEM_A_W'(i_q)) & AMASK;
        mem_wd  = buf_q;
        mem_we  = 1'b1;
        i_d     = i_q + LW'(1);
        state_d = (i_q == len_q - LW'(1)) ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy = (state_q != IDLE);
    // Reset wins within its own cycle, so an aborted WRITE never reaches memory.
    if (!rst) begin
      busy   = 1'b0;
      done   = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] cs_q, cs_d;

  always_comb begin
    cs_d = cs_q;
    if (state_q == IDLE && start) cs_d = '0;
    else if (state_q == WRITE)    cs_d = cs_q + buf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) cs_q <= '0;
    else      cs_q <= cs_d;
  end

  assign checksum = cs_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: memory model, expected read/write queues.
module tb_mem_copy_engine;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LW = AW + 1;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [15:0]   src = '0, dst = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, mem_we, mem_re;
  logic [15:0]   mem_a;
  logic [DW-1:0] mem_wd, mem_rd;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] mem [256];
  logic [DW-1:0] mdl [256];
  logic          mem_init = 1'b1;
  int            n_vec = 0, n_err = 0;
  logic [AW-1:0]      rd_q [$];
  logic [AW+DW-1:0]   wr_q [$];

  mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rd(mem_rd)
`ifdef MEM_COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int k);
    if (k >= 10 && k <= 13) return DW'(k - 9);
    if (k == 20) return DW'(7);
    return DW'((k * 37) ^ 'hA500);
  endfunction

  assign mem_rd = mem[mem_a[AW-1:0]];

  always @(posedge clk) begin
    if (mem_init) for (int k = 0; k < 256; k++) mem[k] <= pat(k);
    else if (mem_we) mem[mem_a[AW-1:0]] <= mem_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every memory access the DUT issues must match the head of the expected queues.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    r;
    if (!mem_init) begin
      if (mem_we && mem_re) chk("we_re_both", 32'(mem_we & mem_re), 32'd0);
      if (mem_re) begin
        chk("rd_expected", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          r = rd_q.pop_front();
          chk("rd_addr", 32'(mem_a), 32'(r));
        end
      end
      if (mem_we) begin
        chk("wr_expected", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          chk("wr_addr", 32'(mem_a), 32'(e[AW+DW-1:DW]));
          chk("wr_data", 32'(mem_wd), 32'(e[DW-1:0]));
        end
      end
    end
  end

  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input int l, input bit poke);
    logic [DW-1:0] w;
    int cyc;
    bit got;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DW-1:0] sum;
    sum = '0;
`endif
    for (int k = 0; k < l; k++) begin
      w = mdl[8'(s + 16'(k))];
      rd_q.push_back(8'(s + 16'(k)));
      wr_q.push_back({8'(d + 16'(k)), w});
      mdl[8'(d + 16'(k))] = w;
`ifdef MEM_COPY_CHECKSUM_EN
      sum = sum + w;
`endif
    end
    @(posedge clk); #1;
    src = s; dst = d; len = LW'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src = ~s; dst = ~d; len = '1;
    got = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      if (poke && cyc == 3) begin start = 1'b1; src = 16'h0; dst = 16'h00F0; len = LW'(7); end
      else start = 1'b0;
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc), 32'(2 * l + 1));
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_mem_a", 32'(mem_a), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(sum));
`endif
    @(negedge clk);
    chk("after_done", 32'({busy, done}), 32'd0);
    chk("queues_empty", 32'(rd_q.size() + wr_q.size()), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("checksum_hold", 32'(checksum), 32'(sum));
`endif
    for (int k = 0; k < l; k++) chk("mem_dst", 32'(mem[8'(d + 16'(k))]), 32'(mdl[8'(d + 16'(k))]));
  endtask

  task automatic run_abort();
    for (int k = 0; k < 3; k++) rd_q.push_back(8'(60 + k));
    for (int k = 0; k < 2; k++) begin
      wr_q.push_back({8'(80 + k), mdl[60 + k]});
      mdl[80 + k] = mdl[60 + k];
    end
    @(posedge clk); #1;
    src = 16'd60; dst = 16'd80; len = LW'(5); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cycle_we", 32'(mem_we), 32'd0);
    chk("rst_cycle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_outs", 32'({busy, done, mem_we, mem_re}), 32'd0);
    chk("abort_mem_a", 32'(mem_a), 32'd0);
    chk("abort_mem_wd", 32'(mem_wd), 32'd0);
    chk("abort_queues", 32'(rd_q.size() + wr_q.size()), 32'd0);
    for (int k = 0; k < 5; k++) chk("abort_mem", 32'(mem[80 + k]), 32'(mdl[80 + k]));
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mdl[k] = pat(k);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    chk("rst_outs", 32'({busy, done, mem_we, mem_re}), 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_mem_wd", 32'(mem_wd), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("rst_checksum", 32'(checksum), 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b1;

    run_copy(16'd10, 16'd40, 4, 1'b0);
    for (int k = 0; k < 4; k++) chk("basic_val", 32'(mem[40 + k]), 32'(k + 1));
    run_copy(16'd5, 16'd6, 0, 1'b0);
    run_copy(16'd254, 16'd100, 4, 1'b0);
    run_copy(16'd30, 16'd50, 3, 1'b1);
    run_copy(16'd20, 16'd21, 3, 1'b0);
    for (int k = 0; k < 3; k++) chk("overlap_val", 32'(mem[21 + k]), 32'd7);
    run_abort();
    run_copy(16'd40, 16'd140, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
